// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns controller.
// One 32-bit MixColumn unit is reused over the four state columns.

module mix_column (
    input  logic [31:0] col_i,
    output logic [31:0] col_o
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign a0 = col_i[31:24];
    assign a1 = col_i[23:16];
    assign a2 = col_i[15:8];
    assign a3 = col_i[7:0];

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // 3*a is xtime(a)^a; each row is the circulant {2,3,1,1}
    assign col_o[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    assign col_o[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    assign col_o[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    assign col_o[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

module mix_columns_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] st_q, st_d;
    logic [31:0]  mc_in, mc_out;
    logic [127:0] st_mixed;

    // Pick column col of the state for the shared MixColumn unit
    always_comb begin
        mc_in = 32'h0;
        unique case (col_q)
            2'd0: mc_in = st_q[127:96];
            2'd1: mc_in = st_q[95:64];
            2'd2: mc_in = st_q[63:32];
            2'd3: mc_in = st_q[31:0];
            default: mc_in = 32'h0;
        endcase
    end

    mix_column u_mix (
        .col_i (mc_in),
        .col_o (mc_out)
    );

    // State with column col replaced by its mixed value
    always_comb begin
        st_mixed = st_q;
        unique case (col_q)
            2'd0: st_mixed[127:96] = mc_out;
            2'd1: st_mixed[95:64]  = mc_out;
            2'd2: st_mixed[63:32]  = mc_out;
            2'd3: st_mixed[31:0]   = mc_out;
            default: st_mixed = st_q;
        endcase
    end

    // Next-state, handshake outputs and datapath updates
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        st_d      = st_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
            end
            BUSY: begin
                st_d  = st_mixed;
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Accept from IDLE, or from DONE in the same cycle as the drain
        if (in_valid && in_ready) begin
            st_d    = in_state;
            col_d   = 2'd0;
            state_d = in_bypass ? DONE : BUSY;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            st_q    <= 128'h0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            st_q    <= st_d;
        end
    end

    assign out_state = st_q;
    assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: directed cases plus a randomized
// regression scored against a GF(2^8) MixColumns model.

module tb_mix_columns_seq;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    mix_columns_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int n_out = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: multiply in GF(2^8) by shift-and-add, poly 0x11b
    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Reference: out[r] = sum_k M[r][k]*a[k], M circulant of {2,3,1,1}
    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   b;
        logic [127:0] r = 128'h0;
        coef[0] = 8'h02; coef[1] = 8'h03;
        coef[2] = 8'h01; coef[3] = 8'h01;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 4; k++)
                a[k] = s[127 - 32*c - 8*k -: 8];
            for (int rw = 0; rw < 4; rw++) begin
                b = 8'h0;
                for (int k = 0; k < 4; k++)
                    b ^= gmul(coef[(k - rw + 4) % 4], a[k]);
                r[127 - 32*c - 8*rw -: 8] = b;
            end
        end
        return r;
    endfunction

    typedef struct {
        logic [127:0] exp;
        int           acc;
        logic         byp;
    } item_t;

    item_t q[$];
    bit    seen;

    // Scoreboard: latency to first out_valid, data and ordering.
    // Non-bypass results appear after 4 BUSY cycles, so the first
    // edge that sees out_valid is accept+5; bypass is accept+1.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            seen = 1'b0;
        end else begin
            if (out_valid && !seen) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 0, 1);
                end else begin
                    chk("latency", cyc - q[0].acc, q[0].byp ? 1 : 5);
                end
                seen = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (q.size() != 0) begin
                    chk("data", out_state, q[0].exp);
                    void'(q.pop_front());
                end
                seen = 1'b0;
                n_out++;
            end
            if (in_valid && in_ready) begin
                q.push_back('{in_bypass ? in_state : mix_ref(in_state),
                              cyc, in_bypass});
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] s, input logic b,
                        output int acc);
        in_valid  = 1'b1;
        in_state  = s;
        in_bypass = b;
        for (int i = 0; i < 40; i++) begin
            if (in_ready) begin
                step();
                in_valid = 1'b0;
                acc = cyc;
                return;
            end
            step();
        end
        chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        acc = -1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            if (out_valid) return;
            step();
        end
        chk("valid_timeout", 0, 1);
    endtask

    int           a1, a2, a3, a4;
    int           base, sent;
    bit           pend;
    logic [127:0] bp;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_state  = '0;
        in_bypass = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // Known-answer non-bypass transfer
        send(128'hdb135345_f20a225c_01010101_2d26314c, 1'b0, a1);
        for (int i = 0; i < 4; i++) begin
            chk("kat_busy", busy, 1);
            chk("kat_nvalid", out_valid, 0);
            chk("kat_in_ready", in_ready, 0);
            step();
        end
        chk("kat_valid", out_valid, 1);
        chk("kat_busy_end", busy, 0);
        chk("kat_data", out_state,
            128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8);
        step();

        // Bypass transfer returns the state unchanged
        send(128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff, 1'b1, a1);
        chk("byp_valid", out_valid, 1);
        chk("byp_data", out_state,
            128'hc6c6c6c6_d4d4d4d5_00000000_ffffffff);
        step();
        chk("byp_idle", out_valid, 0);

        // Back-pressure holds the result stable
        out_ready = 1'b0;
        bp = 128'hd4d4d4d5_0badcafe_12345678_9abcdef0;
        send(bp, 1'b0, a1);
        wait_valid();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", out_valid, 1);
            chk("bp_col0", out_state[127:96], 32'hd5d5d7d6);
            chk("bp_stable", out_state, mix_ref(bp));
            chk("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("bp_idle_valid", out_valid, 0);
        chk("bp_idle_ready", in_ready, 1);
        chk("bp_idle_busy", busy, 0);

        // Back-to-back accepts overlap the output transfer
        send({4{32'h11223344}}, 1'b0, a1);
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b0, a2);
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, a3);
        send({$urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, a4);
        chk("b2b_period_mix", a2 - a1, 5);
        chk("b2b_mix_to_byp", a3 - a2, 5);
        chk("b2b_period_byp", a4 - a3, 1);
        step();
        step();
        chk("b2b_drain", q.size(), 0);

        // Reset during the second BUSY cycle discards the transfer
        send({4{32'h89abcdef}}, 1'b0, a1);
        step();
        rst_n = 1'b0;
        step();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", in_ready, 1);
        rst_n = 1'b1;
        step();
        send({4{32'h01010101}}, 1'b0, a1);
        wait_valid();
        chk("post_rst_lat", cyc - a1, 4);
        chk("post_rst_data", out_state, {4{32'h01010101}});
        step();

        // Random regression with random stalls on both sides
        base = n_out;
        sent = 0;
        pend = 1'b0;
        for (int t = 0; t < 40000 &&
             (sent < 1000 || n_out - base < 1000); t++) begin
            step();
            if (pend) begin
                sent++;
                in_valid = 1'b0;
            end
            if (!in_valid && sent < 1000 && $urandom_range(0, 3) != 0) begin
                in_valid  = 1'b1;
                in_state  = {$urandom(), $urandom(), $urandom(), $urandom()};
                in_bypass = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            pend = in_valid && in_ready;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("rnd_sent", sent, 1000);
        chk("rnd_outputs", n_out - base, 1000);
        chk("rnd_drain", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
